// File: rtl/sc_pkg.sv
// Shared types and helpers for the stochastic stream decoder.
// The optional bipolar output is enabled with SC_DEC_BIPOLAR_EN.
package sc_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StAccum,
        StHold
    } sc_dec_state_t;

    function automatic int unsigned window_len(input int unsigned width);
        return 32'd1 << width;
    endfunction

    // Maps a unipolar ones count onto the bipolar scale: 2*count - 2^width.
    function automatic int bipolar_value(input int unsigned count, input int unsigned width);
        return 2 * int'(count) - int'(window_len(width));
    endfunction

endpackage

// File: rtl/sc_window_counter.sv
// Counts valid bits within one decode window and flags the final bit of the window.
module sc_window_counter
    import sc_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic en,
    output logic done
);

    localparam logic [WIDTH:0] LastCount = (WIDTH + 1)'(window_len(WIDTH) - 1);

    logic [WIDTH:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Terminal flag is combinational so completion lands on the same edge as the last bit.
    assign done = en && (cnt_q == LastCount);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/sc_stream_decoder.sv
// Counts ones over a window of 2^WIDTH valid stochastic bits and presents the count via valid/ready.
// Defining SC_DEC_BIPOLAR_EN adds a registered bipolar view of the result.
module sc_stream_decoder
    import sc_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    bit_in,
    input  logic                    bit_valid,
    output logic                    busy,
    output logic [WIDTH:0]          result,
    output logic                    result_valid,
    input  logic                    result_ready
`ifdef SC_DEC_BIPOLAR_EN
    ,
    output logic signed [WIDTH+1:0] result_bipolar
`endif
);

    sc_dec_state_t  state_q, state_d;
    logic [WIDTH:0] ones_q, ones_d;
    logic [WIDTH:0] result_q, result_d;
    logic           valid_q, valid_d;
    logic           busy_q, busy_d;
    logic           cnt_clear;
    logic           cnt_en;
    logic           cnt_done;

    assign cnt_en = (state_q == StAccum) && bit_valid;

    sc_window_counter #(
        .WIDTH(WIDTH)
    ) u_window_counter (
        .clk  (clk),
        .rst_n(rst_n),
        .clear(cnt_clear),
        .en   (cnt_en),
        .done (cnt_done)
    );

    always_comb begin
        state_d   = state_q;
        ones_d    = ones_q;
        result_d  = result_q;
        valid_d   = valid_q;
        busy_d    = busy_q;
        cnt_clear = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d   = StAccum;
                    busy_d    = 1'b1;
                    ones_d    = '0;
                    cnt_clear = 1'b1;
                end
            end
            StAccum: begin
                if (bit_valid) begin
                    ones_d = ones_q + {{WIDTH{1'b0}}, bit_in};
                    if (cnt_done) begin
                        result_d = ones_d;
                        valid_d  = 1'b1;
                        busy_d   = 1'b0;
                        state_d  = StHold;
                    end
                end
            end
            StHold: begin
                if (result_ready) begin
                    valid_d = 1'b0;
                    if (start) begin
                        state_d   = StAccum;
                        busy_d    = 1'b1;
                        ones_d    = '0;
                        cnt_clear = 1'b1;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            ones_q   <= '0;
            result_q <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ones_q   <= ones_d;
            result_q <= result_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
        end
    end

    assign busy         = busy_q;
    assign result       = result_q;
    assign result_valid = valid_q;

`ifdef SC_DEC_BIPOLAR_EN
    localparam logic signed [WIDTH+1:0] BipolarReset = (WIDTH + 2)'(bipolar_value(0, WIDTH));

    logic signed [WIDTH+1:0] bipolar_q, bipolar_d;

    assign bipolar_d = (WIDTH + 2)'(bipolar_value(32'(result_d), WIDTH));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bipolar_q <= BipolarReset;
        end else begin
            bipolar_q <= bipolar_d;
        end
    end

    assign result_bipolar = bipolar_q;
`endif

endmodule

// File: tb/tb_sc_stream_decoder.sv
// Randomized scoreboard bench for sc_stream_decoder at WIDTH=4 and WIDTH=8.
module tb_sc_stream_decoder;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // WIDTH=4 instance
    logic       start4, bi4, bv4, rdy4, busy4, v4;
    logic [4:0] r4;
    // WIDTH=8 instance
    logic       start8, bi8, bv8, rdy8, busy8, v8;
    logic [8:0] r8;
`ifdef SC_DEC_BIPOLAR_EN
    logic signed [5:0]  bip4;
    logic signed [9:0]  bip8;
`endif

    sc_stream_decoder #(.WIDTH(4)) dut4 (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start4),
        .bit_in      (bi4),
        .bit_valid   (bv4),
        .busy        (busy4),
        .result      (r4),
        .result_valid(v4),
        .result_ready(rdy4)
`ifdef SC_DEC_BIPOLAR_EN
        ,
        .result_bipolar(bip4)
`endif
    );

    sc_stream_decoder #(.WIDTH(8)) dut8 (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start8),
        .bit_in      (bi8),
        .bit_valid   (bv8),
        .busy        (busy8),
        .result      (r8),
        .result_valid(v8),
        .result_ready(rdy8)
`ifdef SC_DEC_BIPOLAR_EN
        ,
        .result_bipolar(bip8)
`endif
    );

    int tests = 0;
    int fails = 0;
    int q4[$];
    int q8[$];

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitors: pop on each new result, then require it to stay put while held.
    logic pv4 = 1'b0, pv8 = 1'b0;
    int   held4, held8;

    always @(negedge clk) begin
        if (v4 && !pv4) begin
            if (q4.size() == 0) begin
                check("unexpected_result4", 1, 0);
            end else begin
                held4 = q4.pop_front();
                check("result4", int'(r4), held4);
`ifdef SC_DEC_BIPOLAR_EN
                check("bipolar4", int'(bip4), 2 * held4 - 16);
`endif
            end
        end else if (v4 && pv4) begin
            check("hold_stable4", int'(r4), held4);
        end
        pv4 = v4;
    end

    always @(negedge clk) begin
        if (v8 && !pv8) begin
            if (q8.size() == 0) begin
                check("unexpected_result8", 1, 0);
            end else begin
                held8 = q8.pop_front();
                check("result8", int'(r8), held8);
`ifdef SC_DEC_BIPOLAR_EN
                check("bipolar8", int'(bip8), 2 * held8 - 256);
`endif
            end
        end else if (v8 && pv8) begin
            check("hold_stable8", int'(r8), held8);
        end
        pv8 = v8;
    end

    // One 16-bit window on the WIDTH=4 instance with up to gap_max idle cycles before each bit.
    task automatic run4(input logic [15:0] bits, input int unsigned gap_max, input bit do_start);
        int unsigned g;
        q4.push_back($countones(bits));
        if (do_start) begin
            start4 = 1'b1;
            step();
            start4 = 1'b0;
        end
        for (int i = 0; i < 16; i++) begin
            g = (gap_max == 0) ? 0 : $urandom_range(gap_max, 0);
            for (int k = 0; k < int'(g); k++) begin
                bv4 = 1'b0;
                bi4 = 1'($urandom);
                check("busy_gap4", int'(busy4), 1);
                step();
            end
            bv4 = 1'b1;
            bi4 = bits[i];
            check("busy_win4", int'(busy4), 1);
            check("valid_win4", int'(v4), 0);
            step();
        end
        bv4 = 1'b0;
        check("latency_valid4", int'(v4), 1);
        check("latency_busy4", int'(busy4), 0);
    endtask

    task automatic ack4();
        rdy4 = 1'b1;
        step();
        rdy4 = 1'b0;
        check("ack_valid4", int'(v4), 0);
        check("ack_busy4", int'(busy4), 0);
    endtask

    logic [15:0] bits;
    logic [15:0] lfsr;
    logic        w8[256];
    int          cnt8;

    initial begin
        rst_n  = 1'b0;
        start4 = 1'b0; bi4 = 1'b0; bv4 = 1'b0; rdy4 = 1'b0;
        start8 = 1'b0; bi8 = 1'b0; bv8 = 1'b0; rdy8 = 1'b0;
        repeat (3) step();
        check("rst_busy4", int'(busy4), 0);
        check("rst_valid4", int'(v4), 0);
        check("rst_result4", int'(r4), 0);
        check("rst_busy8", int'(busy8), 0);
        check("rst_result8", int'(r8), 0);
`ifdef SC_DEC_BIPOLAR_EN
        check("rst_bipolar4", int'(bip4), -16);
        check("rst_bipolar8", int'(bip8), -256);
`endif
        rst_n = 1'b1;
        step();

        // All ones, back to back
        run4(16'hFFFF, 0, 1'b1);
        ack4();
        // Alternating and all zeros
        run4(16'h5555, 0, 1'b1);
        ack4();
        run4(16'h0000, 1, 1'b1);
        ack4();

        // Valid bits while idle must not be counted
        for (int i = 0; i < 4; i++) begin
            bv4 = 1'b1; bi4 = 1'b1; rdy4 = 1'($urandom);
            step();
        end
        bv4 = 1'b0; rdy4 = 1'b0;
        bits = '0;
        while ($countones(bits) < 5) bits[$urandom_range(15, 0)] = 1'b1;
        run4(bits, 2, 1'b1);

        // Held result with start toggling and no ready
        for (int i = 0; i < 10; i++) begin
            start4 = 1'($urandom);
            bv4 = 1'($urandom); bi4 = 1'($urandom);
            step();
            check("hold_valid4", int'(v4), 1);
            check("hold_busy4", int'(busy4), 0);
        end
        bv4 = 1'b0;
        rdy4 = 1'b1; start4 = 1'b1;
        step();
        rdy4 = 1'b0; start4 = 1'b0;
        check("restart_valid4", int'(v4), 0);
        check("restart_busy4", int'(busy4), 1);
        bits = 16'($urandom);
        run4(bits, 1, 1'b0);
        ack4();

        // Asynchronous reset in the middle of a window
        start4 = 1'b1; step(); start4 = 1'b0;
        for (int i = 0; i < 7; i++) begin
            bv4 = 1'b1; bi4 = 1'b1;
            step();
        end
        bv4 = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("async_busy4", int'(busy4), 0);
        check("async_valid4", int'(v4), 0);
        check("async_result4", int'(r4), 0);
        step();
        rst_n = 1'b1;
        step();
        run4(16'hFFFF, 0, 1'b1);
        ack4();

        // A few random windows
        for (int n = 0; n < 6; n++) begin
            bits = 16'($urandom);
            run4(bits, 3, 1'b1);
            ack4();
        end

        // WIDTH=8, p=0.25 from an LFSR comparator
        lfsr = 16'($urandom_range(65535, 1));
        cnt8 = 0;
        for (int i = 0; i < 256; i++) begin
            lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            w8[i] = (lfsr[7:0] < 8'd64);
            cnt8 += int'(w8[i]);
        end
        q8.push_back(cnt8);
        start8 = 1'b1; step(); start8 = 1'b0;
        for (int i = 0; i < 256; i++) begin
            if ($urandom_range(3, 0) == 0) begin
                bv8 = 1'b0;
                step();
            end
            bv8 = 1'b1; bi8 = w8[i];
            check("busy_win8", int'(busy8), 1);
            step();
        end
        bv8 = 1'b0;
        check("latency_valid8", int'(v8), 1);
        check("latency_busy8", int'(busy8), 0);
        step();
        rdy8 = 1'b1; step(); rdy8 = 1'b0;
        check("ack_valid8", int'(v8), 0);

        step();
        check("queue_empty4", q4.size(), 0);
        check("queue_empty8", q8.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global time guard
    initial begin
        #2000000;
        $display("FAIL timeout: got 1, expected 0");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/sc_stream_decoder.md
Name: sc_stream_decoder

Overview:
- Converts a unipolar stochastic bitstream, such as the output of the stochastic AND multiplier, back to a binary count.
- Counts the ones over a fixed window of 2^WIDTH valid bits and presents the count with a valid/ready handshake.
- Sits at the output boundary of the stochastic datapath and feeds binary logic or host readout.
- Represented probability = result / 2^WIDTH.

Parameters:
- WIDTH, 8: window length exponent; window = 2^WIDTH valid bits; legal range 2..16.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request to begin a new window; honoured only in IDLE, or in HOLD together with result_ready.
- bit_in  input  1  stochastic bitstream sample.
- bit_valid  input  1  qualifies bit_in; sampled only in ACCUM.
- busy  output  1  high while in ACCUM.
- result  output  WIDTH+1  count of ones in the window, 0..2^WIDTH.
- result_valid  output  1  result is held and stable.
- result_ready  input  1  consumer accepts result.
- result_bipolar  output  WIDTH+2 signed  present only with SC_DEC_BIPOLAR_EN.

Behaviour:
- Reset (async assert, sync deassert via clk): state=IDLE, busy=0, result=0, result_valid=0, internal bit counter=0, ones counter=0. Same applies if rst_n is asserted mid-window: the partial count is discarded.
- States: IDLE, ACCUM, HOLD.
- IDLE:
  - start=1 -> ACCUM; bit and ones counters cleared; busy=1 from the next cycle.
  - bit_in is not sampled in the start cycle.
- ACCUM:
  - Each cycle with bit_valid=1 increments the bit counter, and increments the ones counter if bit_in=1.
  - Cycles with bit_valid=0 change nothing.
  - start is ignored.
- Window completion:
  - On the cycle the 2^WIDTH-th valid bit is sampled, the next edge registers result = final ones count (including that bit), sets result_valid=1, clears busy, and goes to HOLD.
  - Latency from the last valid bit to result_valid is 1 cycle.
- HOLD:
  - result and result_valid stay stable until result_ready=1.
  - result_ready=1 with start=0 -> IDLE; result_valid=0 next cycle; result keeps its last value.
  - result_ready=1 with start=1 in the same cycle -> ACCUM directly; result_valid=0, busy=1 next cycle.
  - start without result_ready is ignored.
  - bit_valid is ignored.
- Width rules:
  - The ones counter is WIDTH+1 bits and never wraps; all-ones gives exactly 2^WIDTH.
  - The bit counter is WIDTH+1 bits; the terminal condition is count == 2^WIDTH - 1 with bit_valid=1.
- result_ready outside HOLD has no effect.

Optional Feature:
- SC_DEC_BIPOLAR_EN defined:
  - Adds the result_bipolar port, registered alongside result: result_bipolar = 2*result - 2^WIDTH.
  - Range is -2^WIDTH..+2^WIDTH, representing the bipolar value result_bipolar / 2^WIDTH.
  - Reset value is -2^WIDTH.
- SC_DEC_BIPOLAR_EN undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package sc_pkg:
  - state enum typedef sc_dec_state_t (IDLE, ACCUM, HOLD).
  - constant function/localparam for window length 2^WIDTH.
  - bipolar offset helper.
- One sub-module: sc_window_counter. It holds the bit counter with a terminal-count flag (clear, enable inputs; done output). The ones counter and FSM stay in the top.

Test Plan:
1. WIDTH=4, start, then 16 consecutive valid bits all 1 -> result=16, result_valid high exactly 1 cycle after the 16th bit, busy falls on the same edge; bipolar=+16.
2. WIDTH=4, alternating 1,0 for 16 valid bits -> result=8; bipolar=0. All zeros -> result=0; bipolar=-16.
3. WIDTH=4, 16 valid bits containing 5 ones, spread over 30 cycles with bit_valid gaps, plus bit_valid pulses before start -> result=5; pre-start bits not counted; busy high for the whole window.
4. HOLD with result_ready=0 for 10 cycles while start toggles -> result constant, no new window. Then result_ready=1 and start=1 in the same cycle -> result_valid=0 and busy=1 next cycle; the following window counts from 0.
5. rst_n asserted asynchronously mid-window (between clock edges) after 7 valid bits -> busy, result and result_valid go to 0 immediately. After release, start plus 16 all-ones bits -> result=16 (no carry-over).
6. WIDTH=8: 256 valid bits from an LFSR comparator at p=0.25 -> result equals the bench's reference count exactly.
